// File: rtl/serial_add_ctrl.sv
// Bit-serial signed adder/subtractor: one full-adder cell processes the
// operands LSB first, then the result and an overflow-free flag are latched.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             valid
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             valid_q, valid_d;
  logic             s_bit;
  logic [WIDTH-1:0] res_shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      valid_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    valid_d   = valid_q;
    s_bit     = opa_q[0] ^ opb_q[0] ^ carry_q;
    res_shift = {s_bit, res_q[WIDTH-1:1]};

    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1, the +1 entering as the initial carry.
          opa_d    = a;
          opb_d    = sub ? ~b : b;
          carry_d  = sub;
          cnt_d    = '0;
          sign_a_d = a[WIDTH-1];
          sign_b_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
          state_d  = ADD;
        end
      end
      ADD: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
        res_d   = res_shift;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          sum_d   = res_shift;
          valid_d = !((sign_a_q == sign_b_q) && (sign_a_q != s_bit));
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == ADD);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign valid = valid_q;

endmodule
